exe_stage: RTL
==============

EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 Parameter DS_TO_ES_BUS_WD, default 163, width of the decode-to-execute bus.
REQ-002 Parameter ES_TO_MS_BUS_WD, default 75, width of the execute-to-memory bus.
REQ-003 Parameter ES_TO_ID_BUS_WD, default 39, width of the forwarding bus to decode.
REQ-004 Port clk, in, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, in, 1: synchronous, active-high reset.
REQ-006 Port ds_to_es_valid, in, 1: decode offers an instruction.
REQ-007 Port ds_to_es_bus, in, 163. Fields:
  - [162:144] alu_op
  - [143:139] load_op {ld_hu,ld_bu,ld_h,ld_b,ld_w}
  - [138:136] st_op {st_h,st_b,st_w}
  - [135] src1_is_pc, [134] src2_is_imm, [133] gr_we, [132:128] dest
  - [127:96] imm, [95:64] rj_value, [63:32] rkd_value, [31:0] pc
REQ-008 Port es_allowin, out, 1: execute can accept an instruction this cycle.
REQ-009 Port ms_allowin, in, 1: memory stage can accept an instruction.
REQ-010 Port es_to_ms_valid, out, 1: execute offers a result to memory stage.
REQ-011 Port es_to_ms_bus, out, 75. Fields: [74:70] load_op, [69] gr_we, [68:64] dest, [63:32] es_result, [31:0] pc.
REQ-012 Port es_to_id_bus, out, 39. Fields: [38] es_rf_wen, [37:33] es_rf_dest, [32:1] es_value, [0] es_ok.
REQ-013 Port data_sram_en, out, 1: data RAM access enable.
REQ-014 Port data_sram_we, out, 4: byte write strobes.
REQ-015 Port data_sram_addr, out, 32: byte address.
REQ-016 Port data_sram_wdata, out, 32: store data.

Function
REQ-017 The stage SHALL hold es_valid and a bus register; the bus register loads only when ds_to_es_valid && es_allowin.
REQ-018 On each clock with es_allowin high, es_valid SHALL load ds_to_es_valid.
REQ-019 Handshake: es_allowin = !es_valid || (es_ready_go && ms_allowin); es_to_ms_valid = es_valid && es_ready_go.
REQ-020 Operand selection: src1 = src1_is_pc ? pc : rj_value; src2 = src2_is_imm ? imm : rkd_value.
REQ-021 alu_op[0..11] SHALL compute in one cycle:
  - add, sub
  - signed slt, unsigned sltu (result 0/1)
  - and, nor, or, xor
  - sll, srl, sra, using shift amount src2[4:0]
  - lu12i (result = src2)
REQ-022 alu_op[12..14] (mul_w, mulh_w, mulh_wu) SHALL compute in one cycle using a 33x33 signed product. Operands are sign- or zero-extended per op; the result is the low or high 32 bits.
REQ-023 alu_op[15..18] (div_w, div_wu, mod_w, mod_wu) SHALL use an internal iterative radix-2 divider with states IDLE, BUSY, DONE.
  - IDLE->BUSY when es_valid, a div op is present and the divider is IDLE; operands are latched then.
  - BUSY lasts 32 cycles on a 5-bit counter; BUSY->DONE when the counter wraps 31->0.
  - DONE->IDLE when es_to_ms_valid && ms_allowin.
REQ-024 Divider results: signed ops divide magnitudes, quotient sign = sign(rj) XOR sign(rk), remainder sign = sign(rj). A zero divisor yields quotient 0xFFFFFFFF and remainder = rj_value for all four ops.
REQ-025 es_ready_go SHALL be 1 for non-div ops and SHALL equal (divider state == DONE) for div ops. A div op therefore reaches es_to_ms_valid exactly 33 cycles after entering execute.
REQ-026 Memory access: data_sram_en = es_valid && ms_allowin && (|load_op || |st_op), so each access issues exactly once. data_sram_addr = es_result.
REQ-027 data_sram_we, gated by es_valid && ms_allowin:
  - st_w: 4'b1111
  - st_h: 4'b0011 << {addr[1],1'b0}
  - st_b: 4'b0001 << addr[1:0]
  - loads and all other ops: 0
REQ-028 data_sram_wdata: st_b {4{rkd[7:0]}}, st_h {2{rkd[15:0]}}, otherwise rkd_value.
REQ-029 Forwarding bus fields:
  - es_rf_wen = es_valid && gr_we
  - es_rf_dest = dest
  - es_value = es_result
  - es_ok = es_ready_go && load_op == 0 (a load or unfinished divide is never marked forwardable)
REQ-030 Simultaneous events: a new instruction SHALL be accepted in the same cycle the current one leaves. The divider SHALL restart only after returning to IDLE, never reusing DONE data.
REQ-031 Unaligned addresses are not checked; the low bits pass through unchanged.

Reset
REQ-032 On reset: es_valid=0, divider IDLE, counter=0; es_to_ms_valid=0, data_sram_en=0, data_sram_we=0, es_rf_wen=0; es_allowin=1 on the next cycle.
REQ-033 Reset during BUSY SHALL abort the divide with no output, regardless of ms_allowin.

Verification
REQ-034 Issue add.w with rj=5, rk=7, ms_allowin=1 -> es_to_ms_valid next cycle; es_result=12; es_to_id_bus={1,dest,12,1}.
REQ-035 Issue div.w with rj=-7, rk=2 -> es_allowin=0 for 33 cycles; es_result=0xFFFFFFFD. Then mod.w with the same operands -> 0xFFFFFFFF.
REQ-036 Issue div.wu with rk=0, rj=0x1234 -> quotient 0xFFFFFFFF; mod.wu with the same operands -> 0x1234.
REQ-037 Issue st.b with addr 0x1003, rkd=0xAB -> we=4'b1000, wdata=0xABABABAB, en high for exactly one cycle. Repeat while ms_allowin held 0 for 3 cycles -> no enable until released.
REQ-038 Issue ld.w -> es_ok=0, es_rf_wen=1. Issue mulh_wu with 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-039 Assert reset at divider cycle 10 -> es_valid=0 next cycle, no es_to_ms_valid. A following add.w completes normally.

Source files
------------

// File: rtl/exe_stage.sv
// exe_stage: pipeline execute stage with single-cycle ALU/multiplier, iterative divider and data RAM request generation
// Ports: clk/reset (sync, active-high); ds_to_es_valid/ds_to_es_bus/es_allowin from decode;
//        es_to_ms_valid/es_to_ms_bus/ms_allowin to memory stage; es_to_id_bus forwarding to decode;
//        data_sram_en/we/addr/wdata data RAM request.
module exe_stage #(
    parameter int DS_TO_ES_BUS_WD = 163,
    parameter int ES_TO_MS_BUS_WD = 75,
    parameter int ES_TO_ID_BUS_WD = 39
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                       es_allowin,
    input  logic                       ms_allowin,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic [ES_TO_ID_BUS_WD-1:0] es_to_id_bus,
    output logic                       data_sram_en,
    output logic [3:0]                 data_sram_we,
    output logic [31:0]                data_sram_addr,
    output logic [31:0]                data_sram_wdata
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic                       es_valid;
    logic [DS_TO_ES_BUS_WD-1:0] bus_r;
    logic                       es_ready_go;

    logic [18:0] alu_op;
    logic [4:0]  load_op;
    logic [2:0]  st_op;
    logic        src1_is_pc;
    logic        src2_is_imm;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [31:0] rj_value;
    logic [31:0] rkd_value;
    logic [31:0] pc;

    assign {alu_op, load_op, st_op, src1_is_pc, src2_is_imm, gr_we, dest, imm, rj_value, rkd_value, pc} = bus_r[162:0];

    always_ff @(posedge clk) begin
        if (reset)
            es_valid <= 1'b0;
        else if (es_allowin)
            es_valid <= ds_to_es_valid;
        if (ds_to_es_valid && es_allowin)
            bus_r <= ds_to_es_bus;
    end

    assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
    assign es_to_ms_valid = es_valid && es_ready_go;

    logic [31:0] src1;
    logic [31:0] src2;
    assign src1 = src1_is_pc ? pc : rj_value;
    assign src2 = src2_is_imm ? imm : rkd_value;

    logic [31:0] add_res;
    logic [31:0] sub_res;
    logic [31:0] sll_res;
    logic [31:0] srl_res;
    logic [31:0] sra_res;
    logic        slt_res;
    logic        sltu_res;
    assign add_res  = src1 + src2;
    assign sub_res  = src1 - src2;
    assign slt_res  = $signed(src1) < $signed(src2);
    assign sltu_res = src1 < src2;
    assign sll_res  = src1 << src2[4:0];
    assign srl_res  = src1 >> src2[4:0];
    assign sra_res  = $signed(src1) >>> src2[4:0];

    // 64-bit extension of the 33-bit operands gives the exact low 64 bits of the 33x33 signed product
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] prod;
    assign mul_a = {{32{alu_op[13] & src1[31]}}, src1};
    assign mul_b = {{32{alu_op[13] & src2[31]}}, src2};
    assign prod  = mul_a * mul_b;

    logic        div_op;
    logic        div_signed;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    assign div_op     = |alu_op[18:15];
    assign div_signed = alu_op[15] | alu_op[17];
    assign neg_a      = div_signed & src1[31];
    assign neg_b      = div_signed & src2[31];
    assign mag_a      = neg_a ? -src1 : src1;
    assign mag_b      = neg_b ? -src2 : src2;

    logic [1:0]  div_state;
    logic [4:0]  div_cnt;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic [31:0] dividend;
    logic        neg_q;
    logic        neg_r;
    logic        by_zero;
    logic [32:0] r_sh;
    logic [32:0] diff;
    logic        step_sub;

    // restoring division: shift the next dividend bit into the partial remainder each cycle
    assign r_sh     = {rem, quo[31]};
    assign diff     = r_sh - {1'b0, dvs};
    assign step_sub = !diff[32];

    always_ff @(posedge clk) begin
        if (reset) begin
            div_state <= IDLE;
            div_cnt   <= '0;
        end else begin
            case (div_state)
                IDLE: if (es_valid && div_op) begin
                    div_state <= BUSY;
                    div_cnt   <= '0;
                    rem       <= '0;
                    quo       <= mag_a;
                    dvs       <= mag_b;
                    neg_q     <= neg_a ^ neg_b;
                    neg_r     <= neg_a;
                    by_zero   <= src2 == 32'd0;
                    dividend  <= src1;
                end
                BUSY: begin
                    div_cnt <= div_cnt + 5'd1;
                    rem     <= step_sub ? diff[31:0] : r_sh[31:0];
                    quo     <= {quo[30:0], step_sub};
                    if (div_cnt == 5'd31)
                        div_state <= DONE;
                end
                DONE: if (es_to_ms_valid && ms_allowin)
                    div_state <= IDLE;
                default: div_state <= IDLE;
            endcase
        end
    end

    logic [31:0] div_q;
    logic [31:0] div_r;
    assign div_q = by_zero ? 32'hFFFF_FFFF : neg_q ? -quo : quo;
    assign div_r = by_zero ? dividend : neg_r ? -rem : rem;

    assign es_ready_go = div_op ? div_state == DONE : 1'b1;

    logic [31:0] es_result;
    assign es_result = ({32{alu_op[0]}}  & add_res)
                     | ({32{alu_op[1]}}  & sub_res)
                     | ({32{alu_op[2]}}  & {31'b0, slt_res})
                     | ({32{alu_op[3]}}  & {31'b0, sltu_res})
                     | ({32{alu_op[4]}}  & (src1 & src2))
                     | ({32{alu_op[5]}}  & ~(src1 | src2))
                     | ({32{alu_op[6]}}  & (src1 | src2))
                     | ({32{alu_op[7]}}  & (src1 ^ src2))
                     | ({32{alu_op[8]}}  & sll_res)
                     | ({32{alu_op[9]}}  & srl_res)
                     | ({32{alu_op[10]}} & sra_res)
                     | ({32{alu_op[11]}} & src2)
                     | ({32{alu_op[12]}} & prod[31:0])
                     | ({32{alu_op[13] | alu_op[14]}} & prod[63:32])
                     | ({32{alu_op[15] | alu_op[16]}} & div_q)
                     | ({32{alu_op[17] | alu_op[18]}} & div_r);

    // gating on ms_allowin makes each memory access issue exactly once, in the cycle it leaves
    logic mem_go;
    assign mem_go          = es_valid && ms_allowin;
    assign data_sram_en    = mem_go && (|load_op || |st_op);
    assign data_sram_addr  = es_result;
    assign data_sram_we    = !mem_go   ? 4'b0000
                           : st_op[0]  ? 4'b1111
                           : st_op[2]  ? 4'b0011 << {es_result[1], 1'b0}
                           : st_op[1]  ? 4'b0001 << es_result[1:0]
                           : 4'b0000;
    assign data_sram_wdata = st_op[1] ? {4{rkd_value[7:0]}} : st_op[2] ? {2{rkd_value[15:0]}} : rkd_value;

    assign es_to_ms_bus = {load_op, gr_we, dest, es_result, pc};
    assign es_to_id_bus = {es_valid && gr_we, dest, es_result, es_ready_go && load_op == 5'd0};
endmodule
